// File: rtl/seq_decoder_onehot.sv
// Registered binary-to-one-hot decoder with level, timed-pulse and walking-scan output modes.
// Drives strobe / row-select lines; every output comes straight from a flop.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no operation running, Y=0 (or just finished a pulse/scan)
//   ST_LEVEL | Y latched to onehot(SEL) until the next accepted LOAD or EN low
//   ST_PULSE | Y=onehot(SEL) for PULSE_LEN cycles, BUSY high
//   ST_SCAN  | Y walks one lap from SEL, SCAN_DIV cycles per step, BUSY high
module seq_decoder_onehot #(
    parameter int SEL_W     = 3,
    parameter int PULSE_LEN = 4,
    parameter int SCAN_DIV  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  LOAD,
    input  logic [1:0]            MODE,
    input  logic [SEL_W-1:0]      SEL,
    output logic [(2**SEL_W)-1:0] Y,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int OUT_W   = 2 ** SEL_W;
    localparam int TMR_MAX = (PULSE_LEN > SCAN_DIV) ? PULSE_LEN : SCAN_DIV;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    // Timers count down to zero; the reload value is one less than the span.
    localparam logic [TMR_W-1:0] PULSE_RELOAD = TMR_W'(PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] DIV_RELOAD   = TMR_W'(SCAN_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [SEL_W-1:0] STEP_RELOAD  = SEL_W'(OUT_W - 1);
    localparam logic [SEL_W-1:0] IDX_ONE      = SEL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEVEL,
        ST_PULSE,
        ST_SCAN
    } state_t;

    state_t           state, state_nx;
    logic [OUT_W-1:0] y_nx;
    logic             busy_nx;
    logic             done_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic [SEL_W-1:0] steps, steps_nx;
    logic [SEL_W-1:0] idx, idx_nx;
    logic             load_ok;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            Y     <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            tmr   <= '0;
            steps <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            Y     <= y_nx;
            BUSY  <= busy_nx;
            DONE  <= done_nx;
            tmr   <= tmr_nx;
            steps <= steps_nx;
            idx   <= idx_nx;
        end
    end

    // EN is handled separately below; BUSY blocks loads while pulse/scan runs.
    assign load_ok = LOAD && !BUSY && (MODE != MODE_RSVD);

    always_comb begin
        state_nx = state;
        y_nx     = Y;
        busy_nx  = BUSY;
        done_nx  = 1'b0;
        tmr_nx   = tmr;
        steps_nx = steps;
        idx_nx   = idx;

        if (!EN) begin
            state_nx = ST_IDLE;
            y_nx     = '0;
            busy_nx  = 1'b0;
            tmr_nx   = '0;
            steps_nx = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                ST_PULSE: begin
                    if (tmr == '0) begin
                        state_nx = ST_IDLE;
                        y_nx     = '0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        tmr_nx = tmr - TMR_ONE;
                    end
                end

                ST_SCAN: begin
                    if (tmr != '0) begin
                        tmr_nx = tmr - TMR_ONE;
                    end else if (steps == '0) begin
                        state_nx = ST_IDLE;
                        y_nx     = '0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        idx_nx   = '0;
                    end else begin
                        // idx wraps naturally from OUT_W-1 to 0
                        idx_nx   = idx + IDX_ONE;
                        y_nx     = onehot(idx + IDX_ONE);
                        tmr_nx   = DIV_RELOAD;
                        steps_nx = steps - IDX_ONE;
                    end
                end

                default: begin
                    if (load_ok) begin
                        y_nx = onehot(SEL);
                        case (MODE)
                            MODE_PULSE: begin
                                state_nx = ST_PULSE;
                                busy_nx  = 1'b1;
                                tmr_nx   = PULSE_RELOAD;
                                steps_nx = '0;
                                idx_nx   = '0;
                            end
                            MODE_SCAN: begin
                                state_nx = ST_SCAN;
                                busy_nx  = 1'b1;
                                tmr_nx   = DIV_RELOAD;
                                steps_nx = STEP_RELOAD;
                                idx_nx   = SEL;
                            end
                            default: begin
                                state_nx = ST_LEVEL;
                                busy_nx  = 1'b0;
                                tmr_nx   = '0;
                                steps_nx = '0;
                                idx_nx   = '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_decoder_onehot.sv
// Directed bench for seq_decoder_onehot: stimulus pushes hand-derived expected outputs
// into per-DUT queues, a monitor pops one entry per clock and compares.
module tb_seq_decoder_onehot;

    typedef struct {
        logic [15:0] y;
        logic        busy;
        logic        done;
        string       name;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic        CLK = 1'b0;

    logic        rst1 = 1'b1, en1 = 1'b0, load1 = 1'b0;
    logic [1:0]  mode1 = 2'b00;
    logic [2:0]  sel1 = '0;
    logic [7:0]  y1;
    logic        busy1, done1;

    logic        rst2 = 1'b1, en2 = 1'b0, load2 = 1'b0;
    logic [1:0]  mode2 = 2'b00;
    logic [3:0]  sel2 = '0;
    logic [15:0] y2;
    logic        busy2, done2;

    always #5 CLK = ~CLK;

    seq_decoder_onehot #(.SEL_W(3), .PULSE_LEN(4), .SCAN_DIV(2)) dut (
        .CLK(CLK), .RST(rst1), .EN(en1), .LOAD(load1), .MODE(mode1), .SEL(sel1),
        .Y(y1), .BUSY(busy1), .DONE(done1)
    );

    seq_decoder_onehot #(.SEL_W(4), .PULSE_LEN(1), .SCAN_DIV(1)) dut_w4 (
        .CLK(CLK), .RST(rst2), .EN(en2), .LOAD(load2), .MODE(mode2), .SEL(sel2),
        .Y(y2), .BUSY(busy2), .DONE(done2)
    );

    // Drive one cycle of inputs; expected values describe outputs after the next rising edge.
    task automatic step1(input logic r, input logic e, input logic l, input logic [1:0] m,
                         input logic [2:0] s, input logic [7:0] ey, input logic eb,
                         input logic ed, input string nm);
        exp_t x;
        @(negedge CLK);
        rst1 = r; en1 = e; load1 = l; mode1 = m; sel1 = s;
        x.y = {8'h00, ey}; x.busy = eb; x.done = ed; x.name = nm;
        q1.push_back(x);
    endtask

    task automatic step2(input logic r, input logic e, input logic l, input logic [1:0] m,
                         input logic [3:0] s, input logic [15:0] ey, input logic eb,
                         input logic ed, input string nm);
        exp_t x;
        @(negedge CLK);
        rst2 = r; en2 = e; load2 = l; mode2 = m; sel2 = s;
        x.y = ey; x.busy = eb; x.done = ed; x.name = nm;
        q2.push_back(x);
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            n_checks++;
            if ({8'h00, y1} !== e.y || busy1 !== e.busy || done1 !== e.done) begin
                n_fail++;
                $display("FAIL %s: got Y=%h BUSY=%b DONE=%b, want Y=%h BUSY=%b DONE=%b",
                         e.name, y1, busy1, done1, e.y[7:0], e.busy, e.done);
            end
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            n_checks++;
            if (y2 !== e.y || busy2 !== e.busy || done2 !== e.done) begin
                n_fail++;
                $display("FAIL %s: got Y=%h BUSY=%b DONE=%b, want Y=%h BUSY=%b DONE=%b",
                         e.name, y2, busy2, done2, e.y, e.busy, e.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with LOAD/EN asserted.
        step1(1, 1, 1, 2'b00, 3'd5, 8'h00, 0, 0, "rst_c0");
        step1(1, 1, 1, 2'b01, 3'd5, 8'h00, 0, 0, "rst_c1");

        // Level mode.
        step1(0, 1, 1, 2'b00, 3'd5, 8'h20, 0, 0, "lvl_sel5");
        step1(0, 1, 0, 2'b00, 3'd0, 8'h20, 0, 0, "lvl_hold_a");
        step1(0, 1, 0, 2'b00, 3'd0, 8'h20, 0, 0, "lvl_hold_b");
        step1(0, 1, 1, 2'b00, 3'd0, 8'h01, 0, 0, "lvl_sel0");
        step1(0, 1, 1, 2'b00, 3'd3, 8'h08, 0, 0, "lvl_b2b");
        step1(0, 0, 0, 2'b00, 3'd3, 8'h00, 0, 0, "lvl_en_low");
        step1(0, 0, 1, 2'b00, 3'd4, 8'h00, 0, 0, "load_en0");
        step1(0, 1, 1, 2'b00, 3'd1, 8'h02, 0, 0, "lvl_sel1");
        step1(0, 1, 1, 2'b11, 3'd6, 8'h02, 0, 0, "mode11_ign");
        step1(0, 1, 0, 2'b11, 3'd6, 8'h02, 0, 0, "mode11_hold");

        // Pulse from LEVEL, with a LOAD attempt while busy.
        step1(0, 1, 1, 2'b01, 3'd7, 8'h80, 1, 0, "pulse_c1");
        step1(0, 1, 1, 2'b00, 3'd2, 8'h80, 1, 0, "pulse_busy_load");
        step1(0, 1, 0, 2'b00, 3'd2, 8'h80, 1, 0, "pulse_c3");
        step1(0, 1, 0, 2'b00, 3'd2, 8'h80, 1, 0, "pulse_c4");
        step1(0, 1, 0, 2'b00, 3'd2, 8'h00, 0, 1, "pulse_done");
        // Accepted in the DONE cycle, then aborted by EN.
        step1(0, 1, 1, 2'b01, 3'd1, 8'h02, 1, 0, "pulse_nodead");
        step1(0, 0, 0, 2'b01, 3'd1, 8'h00, 0, 0, "pulse_abort");
        step1(0, 1, 0, 2'b01, 3'd1, 8'h00, 0, 0, "pulse_abort_nodone");
        // Reset mid-pulse.
        step1(0, 1, 1, 2'b01, 3'd4, 8'h10, 1, 0, "pulse_pre_rst");
        step1(1, 1, 0, 2'b01, 3'd4, 8'h00, 0, 0, "pulse_rst");
        step1(0, 1, 0, 2'b01, 3'd4, 8'h00, 0, 0, "pulse_rst_nodone");

        // Scan from SEL=6; LOADs during scan must be ignored.
        for (int k = 0; k < 16; k++) begin
            logic [2:0] ix;
            logic [7:0] ey;
            ix = 3'(6 + k / 2);
            ey = 8'h01 << ix;
            if (k == 0) step1(0, 1, 1, 2'b10, 3'd6, ey, 1, 0, "scan_step");
            else        step1(0, 1, 1, 2'b00, 3'(k), ey, 1, 0, "scan_step");
        end
        step1(0, 1, 0, 2'b00, 3'd0, 8'h00, 0, 1, "scan_done");
        step1(0, 1, 0, 2'b00, 3'd0, 8'h00, 0, 0, "scan_after");

        // Scan aborted at step 3.
        for (int k = 0; k < 7; k++) begin
            logic [7:0] ey;
            ey = 8'h01 << (k / 2);
            step1(0, 1, (k == 0), 2'b10, 3'd0, ey, 1, 0, "abort_scan_step");
        end
        step1(0, 0, 0, 2'b10, 3'd0, 8'h00, 0, 0, "abort_scan_en0");
        for (int k = 0; k < 4; k++)
            step1(0, 1, 0, 2'b10, 3'd0, 8'h00, 0, 0, "abort_scan_nodone");

        // SEL_W=4, PULSE_LEN=1, SCAN_DIV=1 build.
        step2(1, 1, 1, 2'b00, 4'd15, 16'h0000, 0, 0, "w4_rst");
        step2(0, 1, 1, 2'b00, 4'd15, 16'h8000, 0, 0, "w4_lvl15");
        step2(0, 1, 1, 2'b01, 4'd3,  16'h0008, 1, 0, "w4_pulse1");
        step2(0, 1, 0, 2'b01, 4'd3,  16'h0000, 0, 1, "w4_pulse_done");
        for (int k = 0; k < 16; k++) begin
            logic [3:0]  ix;
            logic [15:0] ey;
            ix = 4'(14 + k);
            ey = 16'h0001 << ix;
            step2(0, 1, (k == 0), 2'b10, 4'd14, ey, 1, 0, "w4_scan_step");
        end
        step2(0, 1, 0, 2'b10, 4'd14, 16'h0000, 0, 1, "w4_scan_done");
        step2(0, 1, 0, 2'b10, 4'd14, 16'h0000, 0, 0, "w4_scan_after");

        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (q1.size() + q2.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", q1.size() + q2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
